// File: rtl/prt_dp_lib_pkg.sv
// ============================================================================
// Module      : prt_dp_lib_pkg
// Description : Shared types and helpers for the prt_dp_lib CDC arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prt_dp_lib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

    localparam int C_DEF_TO_CYC = 1024;

    // Id width never collapses to zero, even for a single requester.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prt_dp_lib_rr_pick.sv
// ============================================================================
// Module      : prt_dp_lib_rr_pick
// Description : Combinational round-robin picker: first set request at or
//               after the pointer, wrapping modulo P_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prt_dp_lib_rr_pick
    import prt_dp_lib_pkg::*;
#(
    parameter int P_REQ = 4
) (
    input  logic [P_REQ-1:0]              i_req,
    input  logic [id_width(P_REQ)-1:0]    i_ptr,
    output logic                          o_valid,
    output logic [id_width(P_REQ)-1:0]    o_idx
);

    localparam int IDW = id_width(P_REQ);

    int w_cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = P_REQ - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= P_REQ) begin
                w_cand = w_cand - P_REQ;
            end
            if (i_req[w_cand[IDW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prt_dp_lib_cdc_arb.sv
// ============================================================================
// Module      : prt_dp_lib_cdc_arb
// Description : Round-robin scheduler sharing one toggle-handshake vector CDC
//               channel among P_REQ requesters. Optional ack timeout is
//               enabled by defining PRT_DP_LIB_CDC_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prt_dp_lib_cdc_arb
    import prt_dp_lib_pkg::*;
#(
    parameter int P_REQ    = 4,
    parameter int P_WIDTH  = 16,
    parameter int P_GUARD  = 2,
    parameter int P_TO_CYC = C_DEF_TO_CYC
) (
    input  logic                          CLK_IN,
    input  logic                          RST_IN,
    input  logic [P_REQ-1:0]              REQ_IN,
    input  logic [P_REQ*P_WIDTH-1:0]      DAT_IN,
    output logic [P_REQ-1:0]              DONE_OUT,
    output logic                          ERR_OUT,
    output logic                          BUSY_OUT,
    output logic [id_width(P_REQ)-1:0]    CH_ID_OUT,
    output logic [P_WIDTH-1:0]            CH_DAT_OUT,
    output logic                          CH_TGL_OUT,
    input  logic                          CH_ACK_IN
);

    localparam int IDW = id_width(P_REQ);

    generate
        if (P_REQ < 2 || P_REQ > 16 || P_GUARD < 0 || P_GUARD > 15 || P_TO_CYC < 2) begin : g_param_chk
            $error("prt_dp_lib_cdc_arb: parameter out of range");
        end
    endgenerate

    arb_state_t          r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_gid;
    logic [P_WIDTH-1:0]  r_dat;
    logic                r_tgl;
    logic [P_REQ-1:0]    r_done;
    logic                r_err;
    logic [3:0]          r_gcnt;

    logic                w_valid;
    logic [IDW-1:0]      w_idx;
    logic                w_ack;
    logic                w_to;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [P_WIDTH-1:0]  w_slice [P_REQ];

    generate
        for (genvar i = 0; i < P_REQ; i++) begin : g_slice
            assign w_slice[i] = DAT_IN[i*P_WIDTH +: P_WIDTH];
        end
    endgenerate

    prt_dp_lib_rr_pick #(
        .P_REQ   (P_REQ)
    ) u_pick (
        .i_req   (REQ_IN),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_ack     = (r_state == ST_WAIT) && (CH_ACK_IN == r_tgl);
    assign w_ptr_nxt = (int'(r_gid) + 1 == P_REQ) ? '0 : r_gid + 1'b1;

`ifdef PRT_DP_LIB_CDC_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(P_TO_CYC);

    logic [TOW-1:0] r_tocnt;

    // An ack arriving on the expiry cycle takes priority over the timeout.
    assign w_to = (r_state == ST_WAIT) && !w_ack && (int'(r_tocnt) == P_TO_CYC - 1);

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_tocnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tocnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tocnt <= r_tocnt + 1'b1;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_dat   <= '0;
            r_tgl   <= 1'b0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_gcnt  <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gid   <= w_idx;
                        r_dat   <= w_slice[w_idx];
                        r_tgl   <= ~r_tgl;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_ack || w_to) begin
                        r_done  <= P_REQ'(1) << r_gid;
                        r_ptr   <= w_ptr_nxt;
                        r_gcnt  <= '0;
                        r_state <= (P_GUARD == 0) ? ST_IDLE : ST_GUARD;
                    end
                    // Realign the toggle so the abandoned word is not left pending.
                    if (w_to) begin
                        r_err <= 1'b1;
                        r_tgl <= CH_ACK_IN;
                    end
                end
                ST_GUARD: begin
                    if (int'(r_gcnt) >= P_GUARD - 1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DONE_OUT   = r_done;
    assign ERR_OUT    = r_err;
    assign BUSY_OUT   = (r_state != ST_IDLE);
    assign CH_ID_OUT  = r_gid;
    assign CH_DAT_OUT = r_dat;
    assign CH_TGL_OUT = r_tgl;

endmodule

`default_nettype wire

// File: tb/tb_prt_dp_lib_cdc_arb.sv
// ============================================================================
// Module      : tb_prt_dp_lib_cdc_arb
// Description : Self-checking bench for prt_dp_lib_cdc_arb; acts as the
//               requesters and the destination side of the channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prt_dp_lib_cdc_arb;

`ifdef PRT_DP_LIB_CDC_ARB_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] dat;
    logic        ack;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [1:0]  ch_id;
    logic [15:0] ch_dat;
    logic        ch_tgl;

    int vec = 0;
    int bad = 0;
    int m_ptr;
    bit m_tgl;

    always #5 clk = ~clk;

    prt_dp_lib_cdc_arb #(
        .P_REQ      (4),
        .P_WIDTH    (16),
        .P_GUARD    (2),
        .P_TO_CYC   (TB_TO)
    ) dut (
        .CLK_IN     (clk),
        .RST_IN     (rst),
        .REQ_IN     (req),
        .DAT_IN     (dat),
        .DONE_OUT   (done),
        .ERR_OUT    (err),
        .BUSY_OUT   (busy),
        .CH_ID_OUT  (ch_id),
        .CH_DAT_OUT (ch_dat),
        .CH_TGL_OUT (ch_tgl),
        .CH_ACK_IN  (ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Nearest requester at or after the pointer, wrapping around.
    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_tgl = 1'b0;
        ack   = 1'b0;
    endtask

    // One complete transfer: grant, destination acks after dly cycles, guard.
    task automatic xfer(input logic [3:0] r, input int dly, input bit chg);
        int          g;
        logic [15:0] d;
        req = r;
        g   = model_pick(r);
        d   = dat[g*16 +: 16];
        tick();
        m_tgl = ~m_tgl;
        chk("grant_tgl", ch_tgl, m_tgl);
        chk("grant_id", ch_id, g);
        chk("grant_dat", ch_dat, d);
        chk("busy_wait", busy, 1);
        if (chg) begin
            dat[g*16 +: 16] = d + 16'd1;
            req = 4'b0000;
        end
        repeat (dly) tick();
        chk("no_early_done", done, 0);
        chk("hold_dat", ch_dat, d);
        ack = m_tgl;
        tick();
        chk("done", done, 4'b0001 << g);
        chk("no_err", err, 0);
        chk("hold_id_done", ch_id, g);
        m_ptr = (g + 1) % 4;
        tick();
        chk("done_once", done, 0);
        chk("busy_guard", busy, 1);
        tick();
        chk("idle_after_guard", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg;
        rst = 1'b1;
        req = '0;
        dat = '0;
        model_reset();
        repeat (2) tick();
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", ch_id, 0);
        chk("rst_dat", ch_dat, 0);
        chk("rst_tgl", ch_tgl, 0);
        rst = 1'b0;

        // Single requester on slot 2.
        dat = 64'h0000_BEEF_0000_0000;
        xfer(4'b0100, 5, 1'b0);

        // All requesting: grants rotate 0,1,2,3,0 from a fresh pointer.
        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        dat = 64'h4444_3333_2222_1111;
        for (int i = 0; i < 5; i++) begin
            xfer(4'b1111, 3, 1'b0);
            chk("rr_order", ch_id, i % 4);
        end

        // Pointer wrap after granting slot 3.
        xfer(4'b1000, 2, 1'b0);
        xfer(4'b1001, 2, 1'b0);
        chk("wrap_to_0", ch_id, 0);

        // Data changes mid-WAIT must not reach the channel.
        dat[31:16] = 16'h0001;
        xfer(4'b0010, 4, 1'b1);

        // Reset while a word is in flight.
        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        req = 4'b0100;
        tick();
        chk("pre_rst_tgl", ch_tgl, 1);
        rst = 1'b1;
        tick();
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_id", ch_id, 0);
        chk("midrst_dat", ch_dat, 0);
        chk("midrst_tgl", ch_tgl, 0);
        rst = 1'b0;
        model_reset();
        xfer(4'b0001, 1, 1'b0);
        chk("post_rst_id", ch_id, 0);

        // Randomized traffic, including requests dropped while granted.
        for (int i = 0; i < 25; i++) begin
            dat = {$urandom, $urandom};
            xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

`ifdef PRT_DP_LIB_CDC_ARB_TIMEOUT_EN
        // No ack: timeout fires on the 16th WAIT cycle.
        req = 4'b0010;
        tg  = model_pick(req);
        tick();
        m_tgl = ~m_tgl;
        chk("to_grant_tgl", ch_tgl, m_tgl);
        repeat (15) tick();
        chk("to_pre_err", err, 0);
        tick();
        chk("to_err", err, 1);
        chk("to_done", done, 4'b0001 << tg);
        chk("to_realign", ch_tgl, ack);
        m_tgl = ack;
        m_ptr = (tg + 1) % 4;
        req = '0;
        repeat (2) tick();
        chk("to_idle", busy, 0);

        // Ack on the expiry cycle wins.
        req = 4'b0100;
        tg  = model_pick(req);
        tick();
        m_tgl = ~m_tgl;
        repeat (15) tick();
        ack = m_tgl;
        tick();
        chk("to_race_err", err, 0);
        chk("to_race_done", done, 4'b0001 << tg);
        m_ptr = (tg + 1) % 4;
        req = '0;
        repeat (2) tick();
        chk("to_race_idle", busy, 0);
`else
        tg = 0;
        chk("err_tied_low", err, tg);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

`default_nettype wire
